// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if : requester handshakes, uart_send strobe/busy and status
// Revision: 1.0
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if;
    logic       req0;
    logic [7:0] din0;
    logic       ack0;
    logic       req1;
    logic [7:0] din1;
    logic       ack1;
    logic       uart_en;
    logic [7:0] uart_din;
    logic       uart_tx_busy;
    logic [1:0] grant;
    logic       timeout_err;
    logic       clr_err;

    // master: requesters plus the uart_send side; slave: the arbiter itself
    modport master (
        output req0, din0, req1, din1, uart_tx_busy, clr_err,
        input  ack0, ack1, uart_en, uart_din, grant, timeout_err
    );

    modport slave (
        input  req0, din0, req1, din1, uart_tx_busy, clr_err,
        output ack0, ack1, uart_en, uart_din, grant, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_arbiter : round-robin sharing of one uart_send between two byte
// requesters. Optional per-port byte counters under UART_ARB_STAT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 16,
    parameter int GUARD_CYCLES = 2
`ifdef UART_ARB_STAT_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
`ifdef UART_ARB_STAT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    localparam int TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GUARD     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             uart_en_q, uart_en_d;
    logic [7:0]       uart_din_q, uart_din_d;
    logic             timeout_err_q, timeout_err_d;
    logic             busy_dly_q;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [GRD_W-1:0] guard_cnt_q, guard_cnt_d;
    logic             pick1;
    logic             done_evt;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        uart_en_d     = 1'b0;
        uart_din_d    = uart_din_q;
        // a clear in the same cycle as a new timeout loses to the set below
        timeout_err_d = timeout_err_q & ~bus.clr_err;
        tmo_cnt_d     = tmo_cnt_q;
        guard_cnt_d   = guard_cnt_q;
        pick1         = 1'b0;
        done_evt      = 1'b0;

        case (state_q)
            IDLE: begin
                // stale busy from a foreign source must clear on both samples first
                if ((bus.req0 || bus.req1) && !bus.uart_tx_busy && !busy_dly_q) begin
                    pick1        = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
                    uart_din_d   = pick1 ? bus.din1 : bus.din0;
                    grant_d      = pick1 ? 2'b10 : 2'b01;
                    last_grant_d = pick1;
                    ack0_d       = ~pick1;
                    ack1_d       = pick1;
                    uart_en_d    = 1'b1;
                    tmo_cnt_d    = '0;
                    state_d      = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    grant_d       = 2'b00;
                    guard_cnt_d   = '0;
                    state_d       = GUARD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (busy_dly_q && !bus.uart_tx_busy) begin
                    done_evt    = 1'b1;
                    grant_d     = 2'b00;
                    guard_cnt_d = '0;
                    state_d     = GUARD;
                end
            end
            GUARD: begin
                if (guard_cnt_q == GRD_LAST) begin
                    state_d = IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + GRD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_ARB_STAT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // timed-out transfers never reach WAIT_DONE, so they are not counted
    always_comb begin
        cnt0_d = cnt0_q + CNT_W'(done_evt & grant_q[0]);
        cnt1_d = cnt1_q + CNT_W'(done_evt & grant_q[1]);
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= 2'b00;
            last_grant_q  <= 1'b1;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            uart_en_q     <= 1'b0;
            uart_din_q    <= 8'h00;
            timeout_err_q <= 1'b0;
            busy_dly_q    <= 1'b0;
            tmo_cnt_q     <= '0;
            guard_cnt_q   <= '0;
`ifdef UART_ARB_STAT_EN
            cnt0_q        <= '0;
            cnt1_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            uart_en_q     <= uart_en_d;
            uart_din_q    <= uart_din_d;
            timeout_err_q <= timeout_err_d;
            busy_dly_q    <= bus.uart_tx_busy;
            tmo_cnt_q     <= tmo_cnt_d;
            guard_cnt_q   <= guard_cnt_d;
`ifdef UART_ARB_STAT_EN
            cnt0_q        <= cnt0_d;
            cnt1_q        <= cnt1_d;
`endif
        end
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.uart_en     = uart_en_q;
    assign bus.uart_din    = uart_din_q;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter : directed stimulus with a byte scoreboard and a simple
// uart_send busy model. Build with UART_ARB_STAT_EN to also check counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int BUSY_TIMEOUT = 16;
    localparam int GUARD_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus ();
`ifdef UART_ARB_STAT_EN
    logic [15:0] cnt0, cnt1;
`endif

    uart_tx_arbiter #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef UART_ARB_STAT_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         en_count = 0;
    int         en_cyc = 0;
    int         fall_cyc = 0;
    logic [7:0] last_din;
    logic       prev_busy;
    logic [8:0] expq[$];
    logic [8:0] e;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_send model: busy rises two cycles after the strobe, lasts 10 cycles
    logic bm_busy, bm_wait;
    int   bm_len;
    logic busy_mute = 1'b0;
    logic busy_force = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bm_busy <= 1'b0;
            bm_wait <= 1'b0;
            bm_len  <= 0;
        end else if (bus.uart_en && !busy_mute) begin
            bm_wait <= 1'b1;
        end else if (bm_wait) begin
            bm_wait <= 1'b0;
            bm_busy <= 1'b1;
            bm_len  <= 10;
        end else if (bm_busy) begin
            bm_len <= bm_len - 1;
            if (bm_len == 1) bm_busy <= 1'b0;
        end
    end

    assign bus.uart_tx_busy = bm_busy | busy_force;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic port, input logic [7:0] b);
        expq.push_back({port, b});
    endtask

    task automatic wait_en(input int target, input int limit);
        for (int i = 0; i < limit && en_count < target; i++) @(negedge clk);
        if (en_count < target) begin
            checks++;
            errors++;
            $display("FAIL wait_uart_en: saw %0d strobes, expected %0d", en_count, target);
        end
    endtask

    task automatic wait_busy(input logic v, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.uart_tx_busy == v) break;
        end
        if (i == limit) begin
            checks++;
            errors++;
            $display("FAIL wait_busy: busy stayed %0b, expected %0b", ~v, v);
        end
    endtask

    task automatic wait_quiet();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && bus.grant == 2'b00 && !bus.uart_tx_busy) break;
        end
        if (i == 200) begin
            checks++;
            errors++;
            $display("FAIL wait_quiet: pending=%0d grant=%b", expq.size(), bus.grant);
        end
        tick(GUARD_CYCLES + 2);
    endtask

    // scoreboard monitor, sampled 1ns after the active edge
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            last_din  = 8'h00;
            prev_busy = 1'b0;
        end else begin
            // first edge on which the arbiter samples busy low
            if (prev_busy && !bus.uart_tx_busy) fall_cyc = cyc + 1;
            prev_busy = bus.uart_tx_busy;
            if (bus.uart_en) begin
                en_count++;
                en_cyc = cyc;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_uart_en: din=%h grant=%b, no byte expected", bus.uart_din, bus.grant);
                end else begin
                    e = expq.pop_front();
                    chk("uart_din", {24'd0, bus.uart_din}, {24'd0, e[7:0]});
                    chk("grant_at_en", {30'd0, bus.grant}, e[8] ? 32'd2 : 32'd1);
                    chk("ack0_at_en", {31'd0, bus.ack0}, {31'd0, ~e[8]});
                    chk("ack1_at_en", {31'd0, bus.ack1}, {31'd0, e[8]});
                end
                last_din = bus.uart_din;
            end else begin
                chk("stray_ack", {30'd0, bus.ack0, bus.ack1}, 32'd0);
                chk("uart_din_hold", {24'd0, bus.uart_din}, {24'd0, last_din});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int mark;
        rst_n        = 1'b1;
        bus.req0     = 1'b0;
        bus.din0     = 8'h00;
        bus.req1     = 1'b0;
        bus.din1     = 8'h00;
        bus.clr_err  = 1'b0;
        #2 rst_n     = 1'b0;
        tick(3);
        chk("rst_grant", {30'd0, bus.grant}, 32'd0);
        chk("rst_uart_en", {31'd0, bus.uart_en}, 32'd0);
        chk("rst_uart_din", {24'd0, bus.uart_din}, 32'd0);
        chk("rst_acks", {30'd0, bus.ack0, bus.ack1}, 32'd0);
        chk("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // contention: port 0 first after reset, then strict alternation
        base = en_count;
        push(1'b0, 8'h11); push(1'b1, 8'h22); push(1'b0, 8'h11); push(1'b1, 8'h22);
        bus.din0 = 8'h11; bus.din1 = 8'h22;
        bus.req0 = 1'b1;  bus.req1 = 1'b1;
        wait_en(base + 4, 400);
        bus.req0 = 1'b0;  bus.req1 = 1'b0;
        wait_quiet();
`ifdef UART_ARB_STAT_EN
        chk("cnt0_after_contention", {16'd0, cnt0}, 32'd2);
        chk("cnt1_after_contention", {16'd0, cnt1}, 32'd2);
`endif

        // single request, one-cycle latency, grant held until busy falls
        base = en_count;
        push(1'b0, 8'hA5);
        bus.din0 = 8'hA5; bus.req0 = 1'b1;
        mark = cyc;
        wait_en(base + 1, 50);
        chk("req_to_en_latency", en_cyc - mark, 32'd1);
        bus.req0 = 1'b0;
        wait_busy(1'b1, 20);
        chk("grant_while_busy", {30'd0, bus.grant}, 32'd1);
        wait_busy(1'b0, 40);
        chk("grant_on_busy_fall", {30'd0, bus.grant}, 32'd1);
        tick(1);
        chk("grant_after_done", {30'd0, bus.grant}, 32'd0);
        wait_quiet();
`ifdef UART_ARB_STAT_EN
        chk("cnt0_after_single", {16'd0, cnt0}, 32'd3);
        chk("cnt1_after_single", {16'd0, cnt1}, 32'd2);
`endif

        // guard spacing between back-to-back port 1 bytes
        base = en_count;
        push(1'b1, 8'h33);
        bus.din1 = 8'h33; bus.req1 = 1'b1;
        wait_en(base + 1, 50);
        bus.din1 = 8'h44;
        push(1'b1, 8'h44);
        wait_en(base + 2, 100);
        bus.req1 = 1'b0;
        chk("guard_spacing", en_cyc - fall_cyc, GUARD_CYCLES + 1);
        wait_quiet();

        // timeout with busy never rising
        busy_mute = 1'b1;
        base = en_count;
        push(1'b0, 8'h55);
        bus.din0 = 8'h55; bus.req0 = 1'b1;
        wait_en(base + 1, 50);
        bus.req0 = 1'b0;
        tick(BUSY_TIMEOUT - 1);
        chk("timeout_err_early", {31'd0, bus.timeout_err}, 32'd0);
        chk("grant_before_timeout", {30'd0, bus.grant}, 32'd1);
        tick(1);
        chk("timeout_err_set", {31'd0, bus.timeout_err}, 32'd1);
        chk("grant_after_timeout", {30'd0, bus.grant}, 32'd0);
        wait_quiet();

        // second timeout coinciding with clr_err: set wins, then clear
        base = en_count;
        push(1'b0, 8'h56);
        bus.din0 = 8'h56; bus.req0 = 1'b1;
        wait_en(base + 1, 50);
        bus.req0 = 1'b0;
        tick(BUSY_TIMEOUT - 1);
        chk("timeout_err_sticky", {31'd0, bus.timeout_err}, 32'd1);
        bus.clr_err = 1'b1;
        tick(1);
        chk("timeout_set_wins", {31'd0, bus.timeout_err}, 32'd1);
        tick(1);
        chk("timeout_err_cleared", {31'd0, bus.timeout_err}, 32'd0);
        bus.clr_err = 1'b0;
        busy_mute = 1'b0;
        wait_quiet();

        // still serviced after timeouts
        base = en_count;
        push(1'b0, 8'h66);
        bus.din0 = 8'h66; bus.req0 = 1'b1;
        wait_en(base + 1, 50);
        bus.req0 = 1'b0;
        wait_quiet();
`ifdef UART_ARB_STAT_EN
        chk("cnt0_after_timeouts", {16'd0, cnt0}, 32'd4);
        chk("cnt1_after_timeouts", {16'd0, cnt1}, 32'd4);
`endif

        // stale busy in IDLE blocks grants; port 1 drops its request unserved
        busy_force = 1'b1;
        tick(2);
        base = en_count;
        bus.din0 = 8'h5A; bus.req0 = 1'b1;
        bus.din1 = 8'hBB; bus.req1 = 1'b1;
        tick(4);
        chk("no_grant_while_stale_busy", en_count - base, 32'd0);
        chk("grant_idle_stale_busy", {30'd0, bus.grant}, 32'd0);
        bus.req1 = 1'b0;
        tick(1);
        push(1'b0, 8'h5A);
        mark = cyc;
        busy_force = 1'b0;
        wait_en(base + 1, 50);
        chk("stale_release_latency", en_cyc - mark, 32'd2);
        bus.req0 = 1'b0;
        wait_quiet();

        // reset in WAIT_DONE
        base = en_count;
        push(1'b1, 8'h77);
        bus.din1 = 8'h77; bus.req1 = 1'b1;
        wait_en(base + 1, 50);
        bus.req1 = 1'b0;
        wait_busy(1'b1, 20);
        tick(2);
        chk("grant_before_reset", {30'd0, bus.grant}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", {30'd0, bus.grant}, 32'd0);
        chk("async_rst_uart_din", {24'd0, bus.uart_din}, 32'd0);
        chk("async_rst_uart_en", {31'd0, bus.uart_en}, 32'd0);
        chk("async_rst_acks", {30'd0, bus.ack0, bus.ack1}, 32'd0);
`ifdef UART_ARB_STAT_EN
        chk("async_rst_cnt0", {16'd0, cnt0}, 32'd0);
        chk("async_rst_cnt1", {16'd0, cnt1}, 32'd0);
`endif
        tick(2);
        rst_n = 1'b1;
        tick(1);
        base = en_count;
        push(1'b0, 8'h88); push(1'b1, 8'h99);
        bus.din0 = 8'h88; bus.din1 = 8'h99;
        bus.req0 = 1'b1;  bus.req1 = 1'b1;
        wait_en(base + 2, 100);
        bus.req0 = 1'b0;  bus.req1 = 1'b0;
        wait_quiet();
`ifdef UART_ARB_STAT_EN
        chk("cnt0_after_reset", {16'd0, cnt0}, 32'd1);
        chk("cnt1_after_reset", {16'd0, cnt1}, 32'd1);
`endif
        chk("scoreboard_drained", expq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single `uart_send` transmitter between two byte requesters, for example the Sobel edge-pixel stream and a status/header source.
- Grants requesters round-robin, issues each byte as a one-cycle `uart_en` pulse with stable `uart_din`, and tracks `uart_tx_busy` to detect completion.
- Sits between the requesters and `u_uart_send`. It replaces the ad-hoc busy-falling-edge logic at top level.

Parameters:
- BUSY_TIMEOUT, 16: maximum cycles to wait for `uart_tx_busy` to rise after `uart_en` is pulsed.
- GUARD_CYCLES, 2: idle cycles inserted after `uart_tx_busy` falls, before the next grant (minimum 1).
- CNT_W, 16: width of the per-port byte counters (optional feature only).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0  input  1  port 0 request; held high until ack0
- din0  input  8  port 0 byte; stable while req0 is high
- ack0  output  1  one-cycle pulse: port 0 byte accepted (latched and issued)
- req1  input  1  port 1 request; same rules as port 0
- din1  input  8  port 1 byte
- ack1  output  1  one-cycle pulse: port 1 byte accepted
- uart_en  output  1  one-cycle transmit strobe to `uart_send`
- uart_din  output  8  byte to `uart_send`; held from the `uart_en` pulse until completion
- uart_tx_busy  input  1  busy flag from `uart_send` (same clock domain)
- grant  output  2  one-hot owner of the transmitter; 2'b00 when idle
- timeout_err  output  1  sticky: `uart_tx_busy` never rose within BUSY_TIMEOUT
- clr_err  input  1  synchronous clear of timeout_err

Behaviour:
- Reset values (async, rst_n low):
  - ack0, ack1, uart_en, timeout_err = 0.
  - uart_din = 8'h00, grant = 2'b00.
  - FSM = IDLE, last_grant = 1, so port 0 wins first.
  - Internal busy_d = 0, counters = 0.
- busy_d is uart_tx_busy registered once. Completion event = busy_d & ~uart_tx_busy.
- FSM state IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requesting: grant the port not equal to last_grant.
  - On grant, in the same registered edge: uart_din <= selected din; grant <= one-hot; last_grant <= port; ack(port) <= 1 for one cycle; uart_en <= 1 for one cycle. Go to WAIT_BUSY.
  - Latency from req rising to uart_en/ack high is 1 cycle.
- FSM state WAIT_BUSY:
  - Timeout counter starts at 0.
  - uart_tx_busy == 1: go to WAIT_DONE.
  - Counter reaches BUSY_TIMEOUT-1 with busy still low: set timeout_err, clear grant, go to GUARD.
- FSM state WAIT_DONE:
  - Completion event: clear grant, go to GUARD.
  - No timeout in this state; UART frame length is bounded by `uart_send`.
- FSM state GUARD:
  - Count GUARD_CYCLES, then go to IDLE.
  - Requests arriving here are held pending and never dropped.
- Boundary conditions:
  - A requester dropping req before ack is allowed; it is simply not granted.
  - A request may be reasserted in the cycle after ack; it is serviced after GUARD.
  - uart_din remains stable throughout WAIT_BUSY, WAIT_DONE and GUARD, and changes only at the next grant.
  - Simultaneous clr_err and a new timeout: set wins.
  - Reset mid-transfer: FSM returns to IDLE immediately. `uart_send` is reset by the same rst_n, so no stale busy is expected.
  - uart_tx_busy high while in IDLE (foreign/stale): no grant until it is low. IDLE requires ~uart_tx_busy & ~busy_d before granting.
- Fairness: under continuous requests on both ports, grants alternate 0,1,0,1,...

Optional Feature:
- Macro UART_ARB_STAT_EN.
- When defined, adds outputs cnt0 and cnt1 (CNT_W each). Each increments on the completion event of a byte owned by that port. Counters wrap from all-ones to 0, reset to 0, and do not count timed-out transfers.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Single request: req0=1, din0=8'hA5; model busy rising 2 cycles after uart_en and lasting 10 cycles -> exactly one uart_en pulse, uart_din=8'hA5, one ack0 pulse, grant=2'b01 until busy falls, then 2'b00.
- Contention: req0 and req1 both held high with bytes 8'h11 and 8'h22 for 4 transfers -> sent order 11,22,11,22; ack0 and ack1 alternate; first grant goes to port 0 after reset.
- Guard spacing: back-to-back port 1 requests -> the next uart_en occurs exactly GUARD_CYCLES+1 cycles after the busy falling edge.
- Timeout: busy held at 0 -> timeout_err=1 after 16 cycles in WAIT_BUSY and grant returns to 2'b00; next request is still serviced; clr_err=1 clears the flag.
- Reset mid-transfer: assert rst_n low during WAIT_DONE -> all outputs return to reset values asynchronously; after release, port 0 is granted first.
- With UART_ARB_STAT_EN: 3 port-0 bytes and 2 port-1 bytes complete, plus 1 timeout on port 0 -> cnt0=3, cnt1=2.
